mux_pipe_n: RTL and testbench

//  N-way, WIDTH-bit select mux with a registered, back-pressured output stage.

---
 rtl/mux_pipe_n.sv | 150 +++++++++++++++
 tb/tb_mux_pipe_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N-way, WIDTH-bit select mux with a registered, back-pressured output stage.
//
// The channel picked by sel is accepted into a 2-entry buffer: a main register that drives
// the outputs and a skid register that catches one extra word. Because of the skid entry,
// out_ready never reaches in_ready combinationally. in_ready depends only on sel, rst and
// the buffer occupancy.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   sel        in   SELW     channel select, sampled every cycle
//   in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel valid
//   in_ready   out  N        per-channel ready, at most one bit set
//   out_data   out  WIDTH    registered selected data
//   out_sel    out  SELW     channel index that out_data came from
//   out_valid  out  1        out_data/out_sel valid
//   out_ready  in   1        downstream accepts
//   sel_err    out  1        only with MUX_PIPE_SEL_ERR_EN: sticky flag for a cycle with
//                            sel >= N while any in_valid bit is set; cleared by rst only
//
// Build option: define MUX_PIPE_SEL_ERR_EN to add the sel_err output.

module mux_pipe_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
`ifdef MUX_PIPE_SEL_ERR_EN
  output logic                 sel_err,
`endif
  input  logic                 out_ready
);

  // Buffer occupancy: number of words held (main + skid).
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   main_data_q;
  logic [SELW-1:0]    main_sel_q;
  logic [WIDTH-1:0]   skid_data_q;
  logic [SELW-1:0]    skid_sel_q;

  logic               sel_ok;
  logic               sel_valid;
  logic [WIDTH-1:0]   sel_data;
  logic               accept;
  logic               drain;

  // Decode sel against every channel; an out-of-range sel (N not a power of two)
  // matches nothing, so sel_ok stays low and nothing is accepted.
  always_comb begin
    sel_ok    = 1'b0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        sel_ok    = 1'b1;
        sel_valid = in_valid[i];
        sel_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = !rst && (sel == SELW'(i)) && (state_q != StFull);
    end
  end

  assign accept    = !rst && sel_ok && sel_valid && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign drain     = out_valid && out_ready;

  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_data_q <= sel_data;
            main_sel_q  <= sel;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            // Main word leaves this cycle, so the new word reloads main directly.
            main_data_q <= sel_data;
            main_sel_q  <= sel;
          end else if (accept) begin
            // Main is stalled; park the new word behind it.
            skid_data_q <= sel_data;
            skid_sel_q  <= sel;
            state_q     <= StFull;
          end else if (drain) begin
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          if (drain) begin
            main_data_q <= skid_data_q;
            main_sel_q  <= skid_sel_q;
            state_q     <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

`ifdef MUX_PIPE_SEL_ERR_EN
  logic sel_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (!sel_ok && (|in_valid)) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: a directed vector table against an N=4 instance, plus a short
// hand-written sequence against an N=3 instance for the out-of-range select case.

module tb_mux_pipe_n;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // N = 4 instance
  logic         rst4;
  logic [1:0]   sel4;
  logic [127:0] data4;
  logic [3:0]   vld4;
  logic [3:0]   rdy4;
  logic [31:0]  od4;
  logic [1:0]   os4;
  logic         ov4;
  logic         ordy4;

  // N = 3 instance
  logic         rst3;
  logic [1:0]   sel3;
  logic [95:0]  data3;
  logic [2:0]   vld3;
  logic [2:0]   rdy3;
  logic [31:0]  od3;
  logic [1:0]   os3;
  logic         ov3;
  logic         ordy3;

`ifdef MUX_PIPE_SEL_ERR_EN
  logic         err4;
  logic         err3;
`endif

  mux_pipe_n #(.WIDTH(32), .N(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst4),
    .sel       (sel4),
    .in_data   (data4),
    .in_valid  (vld4),
    .in_ready  (rdy4),
    .out_data  (od4),
    .out_sel   (os4),
    .out_valid (ov4),
`ifdef MUX_PIPE_SEL_ERR_EN
    .sel_err   (err4),
`endif
    .out_ready (ordy4)
  );

  mux_pipe_n #(.WIDTH(32), .N(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .sel       (sel3),
    .in_data   (data3),
    .in_valid  (vld3),
    .in_ready  (rdy3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_valid (ov3),
`ifdef MUX_PIPE_SEL_ERR_EN
    .sel_err   (err3),
`endif
    .out_ready (ordy3)
  );

  int n_chk;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic        chk_d;
    logic [31:0] e_od;
    logic [1:0]  e_os;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic [1:0] sel, input logic [3:0] vld,
                              input logic [31:0] d, input logic ordy, input logic [3:0] e_rdy,
                              input logic e_ov, input logic chk_d, input logic [31:0] e_od,
                              input logic [1:0] e_os);
    vec_t v;
    v.rst = rst; v.sel = sel; v.vld = vld; v.d = d; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.chk_d = chk_d; v.e_od = e_od; v.e_os = e_os;
    return v;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // e_rdy is checked before the edge; e_ov/e_od/e_os after it.
    //               rst  sel  vld      d              ordy  e_rdy    ov    chk   e_od           e_os
    // Reset held two cycles, then sel=0 idle.
    vecs[0]  = mk(1'b1, 2'd0, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b1, 32'h0,        2'd0);
    vecs[1]  = mk(1'b1, 2'd0, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 1'b1, 32'h0,        2'd0);
    vecs[2]  = mk(1'b0, 2'd0, 4'b0000, 32'h0,        1'b0, 4'b0001, 1'b0, 1'b1, 32'h0,        2'd0);
    // Single word on channel 2, then drained.
    vecs[3]  = mk(1'b0, 2'd2, 4'b0100, 32'hDEADBEEF, 1'b1, 4'b0100, 1'b1, 1'b1, 32'hDEADBEEF, 2'd2);
    vecs[4]  = mk(1'b0, 2'd2, 4'b0000, 32'h0,        1'b1, 4'b0100, 1'b0, 1'b0, 32'h0,        2'd0);
    // Stall: fill to FULL with 0x11 then 0x33, a third word is refused, then drain in order.
    vecs[5]  = mk(1'b0, 2'd1, 4'b0010, 32'h11,       1'b0, 4'b0010, 1'b1, 1'b1, 32'h11,       2'd1);
    vecs[6]  = mk(1'b0, 2'd3, 4'b1000, 32'h33,       1'b0, 4'b1000, 1'b1, 1'b1, 32'h11,       2'd1);
    vecs[7]  = mk(1'b0, 2'd3, 4'b1111, 32'h44,       1'b0, 4'b0000, 1'b1, 1'b1, 32'h11,       2'd1);
    vecs[8]  = mk(1'b0, 2'd0, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b1, 1'b1, 32'h33,       2'd3);
    vecs[9]  = mk(1'b0, 2'd0, 4'b0000, 32'h0,        1'b1, 4'b0001, 1'b0, 1'b0, 32'h0,        2'd0);
    // Full throughput across a changing sel.
    vecs[10] = mk(1'b0, 2'd0, 4'b1111, 32'h1,        1'b1, 4'b0001, 1'b1, 1'b1, 32'h1,        2'd0);
    vecs[11] = mk(1'b0, 2'd1, 4'b1111, 32'h2,        1'b1, 4'b0010, 1'b1, 1'b1, 32'h2,        2'd1);
    vecs[12] = mk(1'b0, 2'd2, 4'b1111, 32'h3,        1'b1, 4'b0100, 1'b1, 1'b1, 32'h3,        2'd2);
    vecs[13] = mk(1'b0, 2'd3, 4'b1111, 32'h4,        1'b1, 4'b1000, 1'b1, 1'b1, 32'h4,        2'd3);
    vecs[14] = mk(1'b0, 2'd0, 4'b0000, 32'h0,        1'b1, 4'b0001, 1'b0, 1'b0, 32'h0,        2'd0);
    // Valid only on unselected channels: nothing captured.
    vecs[15] = mk(1'b0, 2'd1, 4'b1101, 32'h55,       1'b1, 4'b0010, 1'b0, 1'b0, 32'h0,        2'd0);
    // Fill to FULL with 0xAA held, reset mid-transfer discards both words.
    vecs[16] = mk(1'b0, 2'd0, 4'b0001, 32'hAA,       1'b0, 4'b0001, 1'b1, 1'b1, 32'hAA,       2'd0);
    vecs[17] = mk(1'b0, 2'd1, 4'b0010, 32'hBB,       1'b0, 4'b0010, 1'b1, 1'b1, 32'hAA,       2'd0);
    vecs[18] = mk(1'b1, 2'd0, 4'b1111, 32'hCC,       1'b0, 4'b0000, 1'b0, 1'b1, 32'h0,        2'd0);
    vecs[19] = mk(1'b0, 2'd1, 4'b0000, 32'h0,        1'b1, 4'b0010, 1'b0, 1'b1, 32'h0,        2'd0);
    vecs[20] = mk(1'b0, 2'd1, 4'b0000, 32'h0,        1'b0, 4'b0010, 1'b0, 1'b1, 32'h0,        2'd0);

    // Hold the N=3 instance in reset while the table runs.
    rst4 = 1'b1; sel4 = '0; vld4 = '0; data4 = '0; ordy4 = 1'b0;
    rst3 = 1'b1; sel3 = '0; vld3 = '0; data3 = '0; ordy3 = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      rst4  = vecs[k].rst;
      sel4  = vecs[k].sel;
      vld4  = vecs[k].vld;
      ordy4 = vecs[k].ordy;
      // Unselected channels carry a poison pattern so a wrong capture is visible.
      for (int i = 0; i < 4; i++) begin
        data4[i*32 +: 32] = (vecs[k].sel == 2'(i)) ? vecs[k].d : (32'hBAD0_0000 | 32'(i));
      end
      #1;
      check($sformatf("v%0d in_ready", k), 32'(rdy4), 32'(vecs[k].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", k), 32'(ov4), 32'(vecs[k].e_ov));
      if (vecs[k].chk_d) begin
        check($sformatf("v%0d out_data", k), od4, vecs[k].e_od);
        check($sformatf("v%0d out_sel", k), 32'(os4), 32'(vecs[k].e_os));
      end
    end

`ifdef MUX_PIPE_SEL_ERR_EN
    check("n4 sel_err never set", 32'(err4), 32'd0);
`endif

    // N = 3: sel = 3 is out of range.
    @(negedge clk);
    rst3 = 1'b1; sel3 = 2'd0; vld3 = 3'b000; ordy3 = 1'b1;
    data3 = {32'h0000_0077, 32'h0000_0066, 32'h0000_0055};
    @(posedge clk); #1;
    check("n3 reset out_valid", 32'(ov3), 32'd0);

    @(negedge clk);
    rst3 = 1'b0; sel3 = 2'd3; vld3 = 3'b111;
    #1;
    check("n3 sel=3 in_ready", 32'(rdy3), 32'd0);
    @(posedge clk); #1;
    check("n3 sel=3 no accept", 32'(ov3), 32'd0);
`ifdef MUX_PIPE_SEL_ERR_EN
    check("n3 sel_err set", 32'(err3), 32'd1);
`endif

    @(negedge clk);
    sel3 = 2'd0; vld3 = 3'b000;
    #1;
    check("n3 sel=0 in_ready", 32'(rdy3), 32'd1);
    @(posedge clk); #1;
    check("n3 still empty", 32'(ov3), 32'd0);
`ifdef MUX_PIPE_SEL_ERR_EN
    check("n3 sel_err sticky", 32'(err3), 32'd1);
`endif

    @(negedge clk);
    sel3 = 2'd2; vld3 = 3'b100;
    #1;
    check("n3 sel=2 in_ready", 32'(rdy3), 32'd4);
    @(posedge clk); #1;
    check("n3 accept out_valid", 32'(ov3), 32'd1);
    check("n3 accept out_data", od3, 32'h0000_0077);
    check("n3 accept out_sel", 32'(os3), 32'd2);

    @(negedge clk);
    rst3 = 1'b1; vld3 = 3'b000;
    @(posedge clk); #1;
    check("n3 rst out_valid", 32'(ov3), 32'd0);
`ifdef MUX_PIPE_SEL_ERR_EN
    check("n3 sel_err cleared", 32'(err3), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
